srgl_multi: RTL
===============

# srgl_multi

Parametrised successor of the single-pattern letter refiner. It streams MPU samples for one movement window and accumulates, in parallel, the sum of absolute differences (SAD) against N_TPL runtime-loadable templates. It then selects the best template whose base letter matches the static letter, and outputs that template's result letter, or the static letter when no template is close enough. It sits between the static-letter classifier (`letra_base`) and the output/UART stage.

## Interface
- `DW`, 32: signed sample width.
- `N_SAMP`, 30: samples per movement window.
- `N_TPL`, 4: number of templates.
- `THRESH`, 2000: maximum accepted SAD (inclusive).
- `ACC_W`, DW+1+$clog2(N_SAMP): accumulator and error width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `mov` in 1: movement window active.
- `mpu_valor` in DW: signed sample.
- `mpu_valid` in 1: sample strobe, one sample per cycle.
- `letra_base` in 8: ASCII letter from the static classifier.
- `tpl_we` in 1: template sample write.
- `tpl_sel` in $clog2(N_TPL): template index.
- `tpl_addr` in $clog2(N_SAMP): sample index.
- `tpl_data` in DW: signed template sample.
- `tpl_cfg_we` in 1: write letters for `tpl_sel` and set its valid bit.
- `tpl_base` in 8: base letter the template refines.
- `tpl_out` in 8: result letter.
- `letra_final` out 8: refined letter.
- `ready` out 1: result valid.
- `match` out 1: a template was accepted.
- `best_err` out ACC_W: winning SAD, all-ones if no candidate.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, CAPTURE, COMPARE, DONE.
- IDLE to CAPTURE when `mov`=1.
  - Latch `letra_base`.
  - Clear the sample counter and all N_TPL accumulators.
  - `mpu_valid` in IDLE is ignored.
- CAPTURE: on each `mpu_valid`, for every template t, acc[t] += |mpu_valor − tpl[t][k]|, then k++.
  - Difference is computed at DW+1 bits signed; the absolute value at DW+1 bits unsigned.
  - No overflow is possible at ACC_W.
- When the N_SAMP-th sample is accepted, go to COMPARE.
- `mov`=0 during CAPTURE: abort to IDLE. `ready`, `letra_final`, `match` and `best_err` are unchanged.
- COMPARE: scan t = 0..N_TPL−1, one per cycle.
  - Candidate: valid[t] and base[t] equals the latched letter.
  - Keep the minimum by strict `<`, so on a tie the lowest index wins.
  - `mov` is ignored during COMPARE.
- End of scan, go to DONE:
  - If the best SAD ≤ THRESH: `letra_final` = out[best], `match`=1.
  - Otherwise: `letra_final` = latched base, `match`=0.
  - `best_err` = best SAD, or all-ones if there was no candidate.
  - `ready`=1.
- DONE holds all outputs and `ready`=1 until `mov`=0, then goes to IDLE with `ready`=0. `letra_final`, `match` and `best_err` keep their values.
- Template writes (`tpl_we`, `tpl_cfg_we`) are honoured only in IDLE and ignored otherwise.
  - `tpl_sel` ≥ N_TPL or `tpl_addr` ≥ N_SAMP: the write is ignored.
  - Template sample RAM is not reset. The valid bits are cleared by reset.

## Timing
- Reset values:
  - State IDLE.
  - `letra_final`=8'h00, `ready`=0, `match`=0, `best_err`=0, `busy`=0.
  - Accumulators 0, valid bits 0.
- A sample is consumed at the rising edge where `mpu_valid`=1 in CAPTURE. Back-to-back valid is supported.
- Latency: with the last sample at edge E, COMPARE spans edges E+1..E+N_TPL and `ready` rises at edge E+N_TPL+1. Default: 5 cycles.
- `mpu_valid` in COMPARE or DONE is dropped.
- A template write is visible to a CAPTURE that starts at least 1 cycle later.
- Reset mid-operation: immediate return to reset values. Templates survive but must be re-enabled with `tpl_cfg_we`.

## Structure
- Package `srgl_pkg`:
  - state enum;
  - ASCII constants for the letters;
  - a function for the ACC_W computation.
- Sub-module `srgl_sad_acc`: one signed abs-diff accumulator with clear and enable, instantiated N_TPL times.
- Template store: one array of N_TPL×N_SAMP×DW registers with a parallel read at index k.

## Test plan
- Template 0 = Z pattern, base 'D', out 'Z'. Inject the identical 30 samples with base 'D', then expect:
  - `ready` 5 cycles after the last sample;
  - `letra_final`='Z', `match`=1, `best_err`=0.
- Same template, constant 5000 input: `letra_final`='D', `match`=0, `best_err` ≫ THRESH.
- Two base-'D' templates, outs 'Z' and 'J', where the input differs by 10 per sample from template 1 and by 100 per sample from template 0: expect 'J', `best_err`=300.
- Identical templates at index 1 and 2: expect the result letter of index 1.
- Base 'A' with no matching template: `letra_final`='A', `best_err`=all-ones.
- Abort and reset cases:
  - Drop `mov` after 10 samples: back to IDLE, `ready` stays 0, outputs unchanged, and the next window starts a fresh SAD.
  - Assert reset in COMPARE: all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/srgl_pkg.sv
// srgl_pkg: shared types and constants for the multi-template letter refiner.
// Holds the FSM state encoding, ASCII letters and accumulator sizing.
package srgl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_COMPARE,
    S_DONE
  } state_e;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] ASCII_B   = 8'h42;
  localparam logic [7:0] ASCII_D   = 8'h44;
  localparam logic [7:0] ASCII_J   = 8'h4A;
  localparam logic [7:0] ASCII_Z   = 8'h5A;

  // Width that holds n_samp worst-case |a-b| terms of dw-bit samples.
  function automatic int acc_width(input int dw, input int n_samp);
    return dw + 1 + $clog2(n_samp);
  endfunction

endpackage

// File: rtl/srgl_sad_acc.sv
// srgl_sad_acc: one signed absolute-difference accumulator.
// Synchronous clear has priority over enable.
module srgl_sad_acc #(
  parameter int DW    = 32,
  parameter int ACC_W = 38
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic [ACC_W-1:0]     acc_o
);

  logic signed [DW:0] diff;
  logic [DW:0]        mag;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;

  always_comb begin
    diff = {a_i[DW-1], a_i} - {b_i[DW-1], b_i};
    mag  = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W-DW-1){1'b0}}, mag};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/srgl_multi.sv
// srgl_multi: streams one movement window, scores it against N_TPL templates
// and refines the static letter with the closest matching template.
module srgl_multi
  import srgl_pkg::*;
#(
  parameter int DW     = 32,
  parameter int N_SAMP = 30,
  parameter int N_TPL  = 4,
  parameter int THRESH = 2000,
  parameter int ACC_W  = acc_width(DW, N_SAMP)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mov,
  input  logic signed [DW-1:0]        mpu_valor,
  input  logic                        mpu_valid,
  input  logic [7:0]                  letra_base,
  input  logic                        tpl_we,
  input  logic [$clog2(N_TPL)-1:0]    tpl_sel,
  input  logic [$clog2(N_SAMP)-1:0]   tpl_addr,
  input  logic signed [DW-1:0]        tpl_data,
  input  logic                        tpl_cfg_we,
  input  logic [7:0]                  tpl_base,
  input  logic [7:0]                  tpl_out,
  output logic [7:0]                  letra_final,
  output logic                        ready,
  output logic                        match,
  output logic [ACC_W-1:0]            best_err,
  output logic                        busy
);

  localparam int SEL_W  = $clog2(N_TPL);
  localparam int CNT_W  = $clog2(N_SAMP);
  localparam int SCAN_W = $clog2(N_TPL + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_SAMP - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(N_TPL);
  localparam logic [SEL_W:0]    TPL_LIM   = (SEL_W + 1)'(N_TPL);
  localparam logic [CNT_W:0]    SAMP_LIM  = (CNT_W + 1)'(N_SAMP);
  localparam logic [ACC_W-1:0]  THR       = ACC_W'(THRESH);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [7:0]        base_q, base_d;
  logic [ACC_W-1:0]  best_q, best_d;
  logic [SEL_W-1:0]  bidx_q, bidx_d;
  logic [7:0]        letra_q, letra_d;
  logic              ready_q, ready_d;
  logic              match_q, match_d;
  logic [ACC_W-1:0]  err_q, err_d;

  logic signed [DW-1:0] tpl_mem [N_TPL][N_SAMP];
  logic [N_TPL-1:0]        valid_q;
  logic [N_TPL-1:0][7:0]   tbase_q;
  logic [N_TPL-1:0][7:0]   tout_q;
  logic [N_TPL-1:0][ACC_W-1:0] acc;

  logic             acc_clr;
  logic             acc_en;
  logic             idle;
  logic             sel_ok;
  logic             addr_ok;
  logic             samp_we;
  logic             cfg_we;
  logic [SEL_W-1:0] scan_idx;
  logic             cand;

  assign idle     = (state_q == S_IDLE);
  assign sel_ok   = ({1'b0, tpl_sel} < TPL_LIM);
  assign addr_ok  = ({1'b0, tpl_addr} < SAMP_LIM);
  assign samp_we  = idle & tpl_we & sel_ok & addr_ok;
  assign cfg_we   = idle & tpl_cfg_we & sel_ok;
  assign scan_idx = scan_q[SEL_W-1:0];
  assign cand     = (scan_q < SCAN_LAST) & valid_q[scan_idx] &
                    (tbase_q[scan_idx] == base_q);

  // Sample RAM is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (samp_we) begin
      tpl_mem[tpl_sel][tpl_addr] <= tpl_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      tbase_q <= '0;
      tout_q  <= '0;
    end else if (cfg_we) begin
      valid_q[tpl_sel] <= 1'b1;
      tbase_q[tpl_sel] <= tpl_base;
      tout_q[tpl_sel]  <= tpl_out;
    end
  end

  for (genvar g = 0; g < N_TPL; g++) begin : g_acc
    srgl_sad_acc #(
      .DW    (DW),
      .ACC_W (ACC_W)
    ) u_acc (
      .clk   (clk),
      .reset (reset),
      .clr_i (acc_clr),
      .en_i  (acc_en),
      .a_i   (mpu_valor),
      .b_i   (tpl_mem[g][cnt_q]),
      .acc_o (acc[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scan_d  = scan_q;
    base_d  = base_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    letra_d = letra_q;
    ready_d = ready_q;
    match_d = match_q;
    err_d   = err_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mov) begin
          state_d = S_CAPTURE;
          base_d  = letra_base;
          cnt_d   = '0;
          acc_clr = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (!mov) begin
          state_d = S_IDLE;
        end else if (mpu_valid) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_COMPARE;
            cnt_d   = '0;
            scan_d  = '0;
            best_d  = '1;
            bidx_d  = '0;
          end
        end
      end
      S_COMPARE: begin
        if (scan_q == SCAN_LAST) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          err_d   = best_q;
          if (best_q <= THR) begin
            letra_d = tout_q[bidx_q];
            match_d = 1'b1;
          end else begin
            letra_d = base_q;
            match_d = 1'b0;
          end
        end else begin
          // Strict < keeps the lowest index on ties.
          if (cand && (acc[scan_idx] < best_q)) begin
            best_d = acc[scan_idx];
            bidx_d = scan_idx;
          end
          scan_d = scan_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!mov) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      scan_q  <= '0;
      base_q  <= ASCII_NUL;
      best_q  <= '0;
      bidx_q  <= '0;
      letra_q <= ASCII_NUL;
      ready_q <= 1'b0;
      match_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      base_q  <= base_d;
      best_q  <= best_d;
      bidx_q  <= bidx_d;
      letra_q <= letra_d;
      ready_q <= ready_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  assign letra_final = letra_q;
  assign ready       = ready_q;
  assign match       = match_q;
  assign best_err    = err_q;
  assign busy        = ~idle;

endmodule
